// File: rtl/truth_table_checker.sv
// truth_table_checker: on-board self-test engine. It steps every input
// vector 0..2**INPUT_SIZE-1 into a combinational DUT. Each vector is held
// for SETTLE_CYCLES cycles. The DUT response is then compared with
// TRUTH_TABLE, and the engine reports the mismatch count and done/pass.
// Optional feature: FIRST_FAIL_CAPTURE_EN. When it is defined, the engine
// records the first failing vector and the response seen for it.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | sweeping vectors, comparing resp at the end of each settle window
// DONE  | results valid and held; start begins a new sweep
module truth_table_checker #(
    parameter int INPUT_SIZE    = 2,
    parameter int OUTPUT_SIZE   = 1,
    parameter logic [(2**INPUT_SIZE)*OUTPUT_SIZE-1:0] TRUTH_TABLE = 4'b1110,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [INPUT_SIZE-1:0]  stim,
    input  logic [OUTPUT_SIZE-1:0] resp,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [INPUT_SIZE:0]    err_count,
    output logic [INPUT_SIZE-1:0]  first_fail_vec,
    output logic [OUTPUT_SIZE-1:0] first_fail_rsp
);

    localparam int NUM_VEC = 2**INPUT_SIZE;
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]      CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [INPUT_SIZE-1:0] LAST_VEC   = INPUT_SIZE'(NUM_VEC - 1);
    localparam logic [INPUT_SIZE:0]   ERR_MAX    = (INPUT_SIZE+1)'(NUM_VEC);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       settle_cnt, settle_cnt_n;
    logic [INPUT_SIZE-1:0]  stim_n;
    logic                   busy_n, done_n, pass_n;
    logic [INPUT_SIZE:0]    err_n, err_upd;
    logic                   mismatch;
    logic [OUTPUT_SIZE-1:0] expected;
    logic [OUTPUT_SIZE-1:0] table_mem [NUM_VEC];

    // The flat truth table is unpacked into one entry per vector so that stim indexes it directly.
    for (genvar k = 0; k < NUM_VEC; k++) begin : g_table
        assign table_mem[k] = TRUTH_TABLE[k*OUTPUT_SIZE +: OUTPUT_SIZE];
    end

    assign expected = table_mem[stim];
    assign mismatch = (resp != expected);
    // The count saturates, although one increment per vector cannot pass NUM_VEC anyway.
    assign err_upd  = (mismatch && err_count != ERR_MAX) ? err_count + 1'b1 : err_count;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [INPUT_SIZE-1:0]  ffv_q, ffv_n;
    logic [OUTPUT_SIZE-1:0] ffr_q, ffr_n;
    assign first_fail_vec = ffv_q;
    assign first_fail_rsp = ffr_q;
`else
    assign first_fail_vec = '0;
    assign first_fail_rsp = '0;
`endif

    // State, vector and result registers; rst overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            ffv_q      <= '0;
            ffr_q      <= '0;
`endif
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            stim       <= stim_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_count  <= err_n;
`ifdef FIRST_FAIL_CAPTURE_EN
            ffv_q      <= ffv_n;
            ffr_q      <= ffr_n;
`endif
        end
    end

    // Next state and next register values. The settle timer counts down and resp is sampled at terminal count.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        stim_n       = stim;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        err_n        = err_count;
`ifdef FIRST_FAIL_CAPTURE_EN
        ffv_n        = ffv_q;
        ffr_n        = ffr_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n      = RUN;
                    settle_cnt_n = CNT_RELOAD;
                    stim_n       = '0;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                    err_n        = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
                    ffv_n        = '0;
                    ffr_n        = '0;
`endif
                end
            end
            RUN: begin
                if (settle_cnt == '0) begin
                    err_n = err_upd;
`ifdef FIRST_FAIL_CAPTURE_EN
                    if (mismatch && err_count == '0) begin
                        ffv_n = stim;
                        ffr_n = resp;
                    end
`endif
                    if (stim == LAST_VEC) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_upd == '0);
                    end else begin
                        stim_n       = stim + 1'b1;
                        settle_cnt_n = CNT_RELOAD;
                    end
                end else begin
                    settle_cnt_n = settle_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker. Instance a uses the default parameters
// (2-input OR table, settle 2). Instance b is a 3-input XOR table with
// settle 1. Expected stim sequences and sweep results are queued when a
// sweep is launched and compared as the DUT produces them.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int err;
        int pass;
        int fvec;
        int frsp;
    } res_t;

    int checks = 0;
    int errors = 0;

    int   stim_q[$];
    res_t res_q[$];

    // ---------------- instance a: defaults ----------------
    localparam logic [3:0] TT_A = 4'b1110;
    logic       rst_a = 1'b1, start_a = 1'b0;
    logic [1:0] stim_a, ffv_a;
    logic [0:0] resp_a, ffr_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    int         mode_a = 0;

    function automatic logic resp_fn_a(int mode, logic [1:0] s);
        case (mode)
            0:       return |s;
            1:       return 1'b0;
            default: return &s;
        endcase
    endfunction

    assign resp_a = resp_fn_a(mode_a, stim_a);

    truth_table_checker u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_rsp(ffr_a)
    );

    // ---------------- instance b: XOR3, settle 1 ----------------
    localparam logic [7:0] TT_B = 8'b1001_0110;
    logic       rst_b = 1'b1, start_b = 1'b0;
    logic [2:0] stim_b, ffv_b;
    logic [0:0] resp_b, ffr_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] err_b;
    int         mode_b = 0;

    assign resp_b = (mode_b == 0) ? ^stim_b : ~^stim_b;

    truth_table_checker #(
        .INPUT_SIZE(3), .OUTPUT_SIZE(1), .TRUTH_TABLE(TT_B), .SETTLE_CYCLES(1)
    ) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_rsp(ffr_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds the expected sweep result from the table and a response function.
    task automatic model_a(input int mode, output res_t r);
        logic [1:0] s;
        logic       rv;
        r = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            s  = 2'(k);
            rv = resp_fn_a(mode, s);
            if (rv != TT_A[k]) begin
`ifdef FIRST_FAIL_CAPTURE_EN
                if (r.err == 0) begin
                    r.fvec = k;
                    r.frsp = int'(rv);
                end
`endif
                r.err++;
            end
        end
        r.pass = (r.err == 0);
    endtask

    task automatic check_result(input string tag, input res_t e, input int done_o,
                                input int pass_o, input int err_o, input int fv, input int fr);
        check({tag, "_done"}, done_o, 1);
        check({tag, "_pass"}, pass_o, e.pass);
        check({tag, "_err"},  err_o,  e.err);
        check({tag, "_ffvec"}, fv, e.fvec);
        check({tag, "_ffrsp"}, fr, e.frsp);
    endtask

    task automatic sweep_a(input string tag, input int mode, input bit poke);
        res_t r, e;
        int   n;
        mode_a = mode;
        model_a(mode, r);
        for (int k = 0; k < 4; k++) begin
            stim_q.push_back(k);
            stim_q.push_back(k);
        end
        res_q.push_back(r);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, "_clr_done"}, int'(done_a), 0);
        check({tag, "_clr_pass"}, int'(pass_a), 0);
        check({tag, "_clr_err"},  int'(err_a), 0);
        n = 0;
        while (busy_a && n < 40) begin
            if (stim_q.size() > 0) check({tag, "_stim"}, int'(stim_a), stim_q.pop_front());
            start_a = poke && (n == 3);
            tick();
            start_a = 1'b0;
            n++;
        end
        check({tag, "_busy_len"}, n, 8);
        check({tag, "_stim_hold"}, int'(stim_a), 3);
        stim_q.delete();
        if (res_q.size() > 0) begin
            e = res_q.pop_front();
            check_result(tag, e, int'(done_a), int'(pass_a), int'(err_a),
                         int'(ffv_a), int'(ffr_a));
        end
        // Results must hold while idle in DONE.
        repeat (3) tick();
        check({tag, "_hold_err"}, int'(err_a), r.err);
        check({tag, "_hold_done"}, int'(done_a), 1);
    endtask

    task automatic sweep_b(input string tag, input int mode);
        res_t r, e;
        logic rv;
        int   n;
        mode_b = mode;
        r = '{0, 0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            rv = (mode == 0) ? ^3'(k) : ~^3'(k);
            if (rv != TT_B[k]) begin
`ifdef FIRST_FAIL_CAPTURE_EN
                if (r.err == 0) begin
                    r.fvec = k;
                    r.frsp = int'(rv);
                end
`endif
                r.err++;
            end
            stim_q.push_back(k);
        end
        r.pass = (r.err == 0);
        res_q.push_back(r);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 40) begin
            if (stim_q.size() > 0) check({tag, "_stim"}, int'(stim_b), stim_q.pop_front());
            tick();
            n++;
        end
        check({tag, "_busy_len"}, n, 8);
        stim_q.delete();
        if (res_q.size() > 0) begin
            e = res_q.pop_front();
            check_result(tag, e, int'(done_b), int'(pass_b), int'(err_b),
                         int'(ffv_b), int'(ffr_b));
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"}, int'(busy_a), 0);
        check({tag, "_done"}, int'(done_a), 0);
        check({tag, "_pass"}, int'(pass_a), 0);
        check({tag, "_err"},  int'(err_a), 0);
        check({tag, "_stim"}, int'(stim_a), 0);
        check({tag, "_ffvec"}, int'(ffv_a), 0);
        check({tag, "_ffrsp"}, int'(ffr_a), 0);
    endtask

    initial begin
        start_a = 1'b1;          // rst must win over start
        repeat (2) tick();
        start_a = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        check_reset_a("reset");
        tick();
        check("idle_busy", int'(busy_a), 0);

        sweep_a("t1_or", 0, 1'b0);
        sweep_a("t2_stuck0", 1, 1'b0);
        sweep_a("t3_and", 2, 1'b0);

        // T4: reset three cycles into a sweep.
        mode_a = 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (2) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check_reset_a("t4_rst");
        sweep_a("t4_fresh", 0, 1'b0);

        // T5: start during busy is ignored; restart from DONE clears a failed result.
        sweep_a("t5_fail", 1, 1'b1);
        sweep_a("t5_recover", 0, 1'b0);

        // T5b: start held high in DONE restarts immediately.
        start_a = 1'b1;
        tick();
        check("held_start_busy", int'(busy_a), 1);
        repeat (8) tick();
        check("held_start_done", int'(done_a), 1);
        tick();
        check("held_start_restart", int'(busy_a), 1);
        start_a = 1'b0;
        repeat (10) tick();
        check("held_start_end_pass", int'(pass_a), 1);

        // T6: XOR3 table.
        sweep_b("t6_xor", 0);
        sweep_b("t6_inv", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
